// File: rtl/cond_sel_pipe_if.sv
// ---------------------------------------------------------------------------
// cond_sel_pipe_if
//   Bundles the input beat (valid/ready, per-channel conditions, channel data)
//   and the output beat (valid/ready, selected data, index, hit flag) of
//   cond_sel_pipe.
//
//   Handshake rule for both sides: a beat transfers on a rising clock edge
//   where valid && ready. A source must hold valid and its payload stable
//   until that transfer. ready may depend combinationally on the consumer's
//   own state but never on valid.
//
//   Modports:
//     slave  - the pipeline itself: consumes in_*, produces out_*, reads out_ready
//     master - the environment: drives in_* and out_ready, observes the rest
// ---------------------------------------------------------------------------
interface cond_sel_pipe_if #(
  parameter int NCH = 4,
  parameter int W   = 8
);
  localparam int SELW = $clog2(NCH);

  logic              in_valid;
  logic              in_ready;
  logic [NCH-1:0]    in_cond;
  logic [NCH*W-1:0]  in_data;

  logic              out_valid;
  logic              out_ready;
  logic [W-1:0]      out_data;
  logic [SELW-1:0]   out_sel;
  logic              out_hit;

  modport slave (
    input  in_valid, in_cond, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel, out_hit
  );

  modport master (
    output in_valid, in_cond, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel, out_hit
  );
endinterface

// File: rtl/cond_sel_pipe.sv
// ---------------------------------------------------------------------------
// cond_sel_pipe
//   Two-stage registered conditional select over NCH W-bit channels.
//   Stage 1 captures the per-channel conditions and data of an accepted beat.
//   Stage 2 registers the word of the winning channel (or DEFAULT when no
//   condition is set), its index and a hit flag.
//
//   Arbitration:
//     MODE 0 - fixed priority, highest asserted index wins (a later condition
//              overrides an earlier one).
//     MODE 1 - round robin, scan starts at rr_ptr and wraps modulo NCH; the
//              pointer moves past the winner only when a valid hit beat
//              advances into stage 2.
//
//   Ports:
//     clk     - rising-edge clock
//     rst_n   - asynchronous active-low reset
//     bus     - cond_sel_pipe_if.slave: in_valid/in_ready/in_cond/in_data and
//               out_valid/out_ready/out_data/out_sel/out_hit
//     rr_ptr  - current round-robin start index (stays 0 in MODE 0), exposed
//               so the arbitration state can be observed
//
//   Both stages advance together under one enable: the pipe moves whenever
//   the output register is empty or being consumed, so the whole pipe holds
//   bit-stable during an output stall.
// ---------------------------------------------------------------------------
module cond_sel_pipe #(
  parameter int           NCH     = 4,
  parameter int           W       = 8,
  parameter int           MODE    = 0,
  parameter logic [W-1:0] DEFAULT = '0,
  localparam int          SELW    = $clog2(NCH)
) (
  input  logic            clk,
  input  logic            rst_n,
  cond_sel_pipe_if.slave  bus,
  output logic [SELW-1:0] rr_ptr
);

  logic              en;
  logic              s1_valid;
  logic [NCH-1:0]    s1_cond;
  logic [NCH*W-1:0]  s1_data;

  logic              hit;
  logic [SELW-1:0]   win;
  logic [SELW-1:0]   rr_next;
  logic [W-1:0]      win_data;

  // Global advance: stage 2 is free or its beat leaves this cycle.
  assign en          = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = en;

  // -------------------------------------------------------------------------
  // Stage 1: capture. Conditions of a non-valid slot are forced to zero so a
  // bubble can never look like a hit further down.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_cond  <= '0;
      s1_data  <= '0;
    end else if (en) begin
      s1_valid <= bus.in_valid;
      s1_cond  <= bus.in_valid ? bus.in_cond : '0;
      s1_data  <= bus.in_data;
    end
  end

  // -------------------------------------------------------------------------
  // Winner selection from the stage-1 contents. win is 0 when nothing hits,
  // which is also the index reported for a no-hit beat.
  // -------------------------------------------------------------------------
  always_comb begin : select
    int   idx;
    logic found;
    hit   = |s1_cond;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    if (MODE == 0) begin
      // Ascending scan, last assignment wins -> highest asserted index.
      for (int i = 0; i < NCH; i++) begin
        if (s1_cond[i]) win = SELW'(i);
      end
    end else begin
      // Rotated scan starting at rr_ptr; the subtract keeps the wrap modulo
      // NCH for non power-of-two channel counts.
      for (int k = 0; k < NCH; k++) begin
        idx = int'(rr_ptr) + k;
        if (idx >= NCH) idx = idx - NCH;
        if (!found && s1_cond[idx]) begin
          found = 1'b1;
          win   = SELW'(idx);
        end
      end
    end
  end

  // Pointer moves one past the winner, wrapping at NCH-1 so it never reaches
  // an index >= NCH.
  assign rr_next  = (win == SELW'(NCH - 1)) ? '0 : win + 1'b1;
  assign win_data = s1_data[int'(win)*W +: W];

  // -------------------------------------------------------------------------
  // Stage 2: registered result and round-robin pointer.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_hit   <= 1'b0;
      bus.out_sel   <= '0;
      bus.out_data  <= '0;
      rr_ptr        <= '0;
    end else if (en) begin
      bus.out_valid <= s1_valid;
      bus.out_hit   <= hit;
      bus.out_sel   <= win;
      bus.out_data  <= hit ? win_data : DEFAULT;
      // Only a real winning beat consumes a round-robin turn.
      if (MODE != 0 && s1_valid && hit) rr_ptr <= rr_next;
    end
  end

endmodule

// File: tb/tb_cond_sel_pipe.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_cond_sel_pipe
//   Three instances share one stimulus stream (identical handshakes):
//     u_a : NCH=4, MODE 0, DEFAULT 8'hA5
//     u_b : NCH=4, MODE 1, DEFAULT 8'h00
//     u_c : NCH=3, MODE 1, DEFAULT 8'h5A (sees in_cond[2:0], in_data[23:0])
// ---------------------------------------------------------------------------
module tb_cond_sel_pipe;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cond_sel_pipe_if #(.NCH(4), .W(8)) bus_a();
  cond_sel_pipe_if #(.NCH(4), .W(8)) bus_b();
  cond_sel_pipe_if #(.NCH(3), .W(8)) bus_c();

  logic [1:0] rr_a, rr_b, rr_c;

  cond_sel_pipe #(.NCH(4), .W(8), .MODE(0), .DEFAULT(8'hA5)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a), .rr_ptr(rr_a));
  cond_sel_pipe #(.NCH(4), .W(8), .MODE(1), .DEFAULT(8'h00)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b), .rr_ptr(rr_b));
  cond_sel_pipe #(.NCH(3), .W(8), .MODE(1), .DEFAULT(8'h5A)) u_c (
    .clk(clk), .rst_n(rst_n), .bus(bus_c), .rr_ptr(rr_c));

  // ---------------- shared drive signals ----------------
  logic        drv_valid;
  logic        drv_ready;
  logic [3:0]  drv_cond;
  logic [31:0] drv_data;

  assign bus_a.in_valid  = drv_valid;
  assign bus_a.in_cond   = drv_cond;
  assign bus_a.in_data   = drv_data;
  assign bus_a.out_ready = drv_ready;
  assign bus_b.in_valid  = drv_valid;
  assign bus_b.in_cond   = drv_cond;
  assign bus_b.in_data   = drv_data;
  assign bus_b.out_ready = drv_ready;
  assign bus_c.in_valid  = drv_valid;
  assign bus_c.in_cond   = drv_cond[2:0];
  assign bus_c.in_data   = drv_data[23:0];
  assign bus_c.out_ready = drv_ready;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Result word: {hit, sel[1:0], data[7:0]}
  function automatic logic [10:0] model(input int nch, input int mode, input logic [7:0] dflt,
                                        input logic [3:0] cond, input logic [31:0] data,
                                        input int ptr);
    int w;
    w = -1;
    if (mode == 0) begin
      for (int i = nch - 1; i >= 0; i--)
        if (w < 0 && cond[i]) w = i;
    end else begin
      for (int k = 0; k < nch; k++) begin
        int j;
        j = (ptr + k) % nch;
        if (w < 0 && cond[j]) w = j;
      end
    end
    if (w < 0) return {1'b0, 2'b00, dflt};
    return {1'b1, 2'(w), data[w*8 +: 8]};
  endfunction

  // ---------------- scoreboard ----------------
  logic [10:0] exp_a[$];
  logic [10:0] exp_b[$];
  logic [10:0] exp_c[$];
  int          mptr_b = 0;
  int          mptr_c = 0;
  logic        stall_prev = 1'b0;
  logic [41:0] snap_prev;

  function automatic logic [41:0] snapshot();
    return {bus_a.out_valid, bus_a.out_hit, bus_a.out_sel, bus_a.out_data, rr_a,
            bus_b.out_valid, bus_b.out_hit, bus_b.out_sel, bus_b.out_data, rr_b,
            bus_c.out_valid, bus_c.out_hit, bus_c.out_sel, bus_c.out_data, rr_c};
  endfunction

  // Inputs and out_ready change just after posedge, so at negedge they hold
  // the values the next posedge will see.
  always @(negedge clk) begin
    logic [10:0] e;
    if (!rst_n) begin
      exp_a.delete(); exp_b.delete(); exp_c.delete();
      mptr_b = 0; mptr_c = 0;
      stall_prev = 1'b0;
    end else begin
      check("in_ready_a", 64'(bus_a.in_ready), 64'(!(bus_a.out_valid && !drv_ready)));
      check("in_ready_c", 64'(bus_c.in_ready), 64'(!(bus_c.out_valid && !drv_ready)));
      if (stall_prev) check("stall_hold", 64'(snapshot()), 64'(snap_prev));

      if (bus_a.out_valid && drv_ready) begin
        if (exp_a.size() == 0) check("unexpected_out_a", 64'(1), 64'(0));
        else check("data_a", 64'({bus_a.out_hit, bus_a.out_sel, bus_a.out_data}), 64'(exp_a.pop_front()));
      end
      if (bus_b.out_valid && drv_ready) begin
        if (exp_b.size() == 0) check("unexpected_out_b", 64'(1), 64'(0));
        else check("data_b", 64'({bus_b.out_hit, bus_b.out_sel, bus_b.out_data}), 64'(exp_b.pop_front()));
      end
      if (bus_c.out_valid && drv_ready) begin
        if (exp_c.size() == 0) check("unexpected_out_c", 64'(1), 64'(0));
        else check("data_c", 64'({bus_c.out_hit, bus_c.out_sel, bus_c.out_data}), 64'(exp_c.pop_front()));
      end

      if (drv_valid && bus_a.in_ready) begin
        exp_a.push_back(model(4, 0, 8'hA5, drv_cond, drv_data, 0));
        e = model(4, 1, 8'h00, drv_cond, drv_data, mptr_b);
        exp_b.push_back(e);
        if (e[10]) mptr_b = (int'(e[9:8]) + 1) % 4;
        e = model(3, 1, 8'h5A, drv_cond, drv_data, mptr_c);
        exp_c.push_back(e);
        if (e[10]) mptr_c = (int'(e[9:8]) + 1) % 3;
      end

      stall_prev = bus_a.out_valid && !drv_ready;
      snap_prev  = snapshot();
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    drv_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
  endtask

  // Present one beat and hold it until accepted (bounded).
  task automatic drive_beat(input logic [3:0] c, input logic [31:0] d);
    logic accepted;
    accepted  = 1'b0;
    drv_valid = 1'b1;
    drv_cond  = c;
    drv_data  = d;
    for (int n = 0; n < 200 && !accepted; n++) begin
      @(negedge clk);
      accepted = bus_a.in_ready;
      @(posedge clk); #1;
    end
    if (!accepted) check("accept_timeout", 64'(0), 64'(1));
    drv_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 200 && (exp_a.size() != 0 || exp_c.size() != 0); n++) idle(1);
    check("drain_empty", 64'(exp_a.size() + exp_b.size() + exp_c.size()), 64'(0));
  endtask

  // Single beat into an empty pipe with out_ready high: checks the exact
  // two-edge latency on u_a against an expected {hit, sel, data}.
  task automatic lat_beat(input logic [3:0] c, input logic [31:0] d, input logic [10:0] exp_word);
    drv_ready = 1'b1;
    idle(2);
    drv_valid = 1'b1;
    drv_cond  = c;
    drv_data  = d;
    @(posedge clk); #1;
    drv_valid = 1'b0;
    check("lat_edge1_valid", 64'(bus_a.out_valid), 64'(0));
    @(posedge clk); #1;
    check("lat_edge2_valid", 64'(bus_a.out_valid), 64'(1));
    check("lat_edge2_word", 64'({bus_a.out_hit, bus_a.out_sel, bus_a.out_data}), 64'(exp_word));
    drain();
  endtask

  // Stream of beats while out_ready follows a pattern (mode 0: 1,0,0 repeating;
  // mode 1: random). Beat data random unless seq is set.
  logic stream_done;
  task automatic run_stream(input int nbeats, input bit random_ready, input bit seq);
    stream_done = 1'b0;
    fork
      begin
        for (int i = 1; i <= nbeats; i++) begin
          if (seq)
            drive_beat(4'(i), {8'(8'h30 + i), 8'(8'h20 + i), 8'(8'h10 + i), 8'(i)});
          else
            drive_beat(4'($urandom_range(0, 15)), $urandom);
          if (!seq) idle($urandom_range(0, 2));
        end
        stream_done = 1'b1;
      end
      begin
        for (int n = 0; n < 5000 && !stream_done; n++) begin
          if (random_ready) drv_ready = ($urandom_range(0, 2) != 0);
          else              drv_ready = ((n % 3) == 0);
          @(posedge clk); #1;
        end
      end
    join
    drv_ready = 1'b1;
    drain();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n     = 1'b0;
    drv_valid = 1'b0;
    drv_ready = 1'b1;
    drv_cond  = '0;
    drv_data  = '0;
    #12;
    check("rst_state_a", 64'({bus_a.out_valid, bus_a.out_hit, bus_a.out_sel, bus_a.out_data}), 64'(0));
    check("rst_state_b", 64'({bus_b.out_valid, bus_b.out_hit, bus_b.out_sel, bus_b.out_data, rr_b}), 64'(0));
    check("rst_state_c", 64'({bus_c.out_valid, bus_c.out_hit, bus_c.out_sel, bus_c.out_data, rr_c}), 64'(0));
    check("rst_in_ready", 64'(bus_a.in_ready), 64'(1));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Fixed priority: channels 0 and 2 asserted -> channel 2.
    lat_beat(4'b0101, 32'h44332211, {1'b1, 2'd2, 8'h33});
    // No hit -> DEFAULT, sel 0, hit 0, still valid.
    lat_beat(4'b0000, 32'h44332211, {1'b0, 2'd0, 8'hA5});

    // Round robin over all-asserted beats, then a single-channel beat.
    do_reset();
    for (int i = 0; i < 4; i++) drive_beat(4'b1111, 32'h44332211);
    drive_beat(4'b0100, 32'h44332211);
    drain();
    check("rr_ptr_b_after5", 64'(rr_b), 64'(3));

    // NCH=3 wrap: ch0 moves the pointer to 1, ch2 wraps it to 0, bubbles and
    // no-hit beats leave it alone, then cond 101 picks channel 0.
    do_reset();
    drive_beat(4'b0001, 32'hDDCCBBAA);
    drain();
    check("rr_ptr_c_after_ch0", 64'(rr_c), 64'(1));
    drive_beat(4'b0100, 32'hDDCCBBAA);
    drain();
    check("rr_ptr_c_wrap", 64'(rr_c), 64'(0));
    idle(3);
    drive_beat(4'b0000, 32'hDDCCBBAA);
    drain();
    check("rr_ptr_c_nohit", 64'(rr_c), 64'(0));
    check("rr_ptr_b_nohit", 64'(rr_b), 64'(3));
    drive_beat(4'b0101, 32'hDDCCBBAA);
    drain();
    check("rr_ptr_c_sel0", 64'(rr_c), 64'(1));
    check("rr_ptr_a_fixed", 64'(rr_a), 64'(0));

    // Backpressure with out_ready 1,0,0 repeating, beats 1..6.
    run_stream(6, 1'b0, 1'b1);
    // Random traffic and random backpressure.
    run_stream(150, 1'b1, 1'b0);

    // Reset with two beats in flight.
    drv_ready = 1'b1;
    idle(2);
    drv_valid = 1'b1; drv_cond = 4'b0010; drv_data = 32'h00001100;
    @(posedge clk); #1;
    drv_cond = 4'b0001; drv_data = 32'h000000EE;
    @(posedge clk); #1;
    drv_valid = 1'b0;
    check("mid_inflight_valid", 64'(bus_a.out_valid), 64'(1));
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_a", 64'({bus_a.out_valid, bus_a.out_hit, bus_a.out_sel, bus_a.out_data}), 64'(0));
    check("mid_rst_out_b", 64'({bus_b.out_valid, bus_b.out_hit, bus_b.out_sel, bus_b.out_data, rr_b}), 64'(0));
    check("mid_rst_rr_c", 64'(rr_c), 64'(0));
    idle(2);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle(1);
      check("post_rst_no_stale", 64'(bus_a.out_valid | bus_b.out_valid | bus_c.out_valid), 64'(0));
    end
    lat_beat(4'b1000, 32'h8899AABB, {1'b1, 2'd3, 8'h88});

    check("final_queue_empty", 64'(exp_a.size() + exp_b.size() + exp_c.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Absolute time guard.
  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
